multifunctional_barrel_shifter: RTL and testbench
=================================================

// Module: multifunctional_barrel_shifter
// PURPOSE
//   Registered 32-bit logical barrel shifter with one direction control.
//   Shifts operand A left or right by 0..31 bit positions in one clock cycle.
//   Sits in a datapath as a single-stage shift unit feeding downstream
//   logic from a registered output.
// PARAMETERS
//   WIDTH    32  data width of A and B (power of two)
//   SHIFT_W   5  shift-amount width, always $clog2(WIDTH)
// PORTS
//   clk    in   1        clock; all state updates on rising edge
//   rst    in   1        reset, synchronous, active-high
//   A      in   WIDTH    operand to shift
//   shift  in   SHIFT_W  shift amount, unsigned, 0..WIDTH-1
//   L      in   1        direction: 1 = shift left, 0 = shift right
//   B      out  WIDTH    shifted result (registered)
// BEHAVIOUR
//   - One clock, clk. Reset rst is synchronous and active-high.
//   - Reset: on a rising clk edge with rst=1, B <= 0. Reset has priority
//     over the data path. While rst is held, B stays 0. The first result
//     appears on the edge after rst falls.
//   - Latency: 1 cycle. A, shift and L sampled at edge n give B valid after
//     edge n. There is no handshake or enable; B updates every cycle.
//   - L=1: B <= A << shift (logical). Vacated LSBs are filled with 0.
//   - L=0: B <= A >> shift (logical). Vacated MSBs are filled with 0.
//     There is no sign extension.
//   - shift=0: B <= A, for either value of L.
//   - shift=WIDTH-1: only A[0] (left) or A[WIDTH-1] (right) survives, and it
//     lands at the opposite end. All other bits are 0.
//   - Combinational core: log2 shifter with SHIFT_W mux levels. Level k shifts
//     by 2^k when shift[k]=1. The direction is handled by bit-reversing A
//     before the levels and bit-reversing the result after them when L=1, so
//     only right-shift levels are built. Only the final result is registered.
//   - No X propagation from unused paths. Every bit of B is driven on every
//     cycle.
// STRUCTURE
//   - Package barrel_pkg: WIDTH, SHIFT_W constants; typedef dir_e
//     {DIR_RIGHT=0, DIR_LEFT=1}; function bit_reverse(WIDTH).
//   - Sub-module barrel_stage #(WIDTH, DIST): one mux level, out = en ?
//     in >> DIST : in. It is instantiated SHIFT_W times with DIST = 1,2,4,8,16.
//   - Top: input reversal mux, stage chain, output reversal mux,
//     output register with synchronous reset.
// TESTING  (A = 32'h2D93FB1A unless stated; check B one cycle after the inputs)
//   1. rst=1 for 2 cycles, any A/shift/L -> B==0. Release rst -> B follows
//      the inputs on the next edge.
//   2. L=0, shift=0,1,4,31 -> B = 2D93FB1A, 16C9FD8D, 02D93FB1, 00000000.
//   3. L=1, shift=0,1,4,31 -> B = 2D93FB1A, 5B27F634, D93FB1A0, 00000000.
//   4. A=32'h80000001: L=0 shift=31 -> 00000001; L=1 shift=31 -> 80000000.
//   5. Sweep L=0 then L=1, shift 0..31, one value per cycle -> each B equals
//      the reference model (A>>s or A<<s). Also check back-to-back changes of
//      L with shift held.
//   6. Assert rst mid-sweep -> B==0 on that edge. Valid results resume the
//      cycle after rst deasserts.

Source files
------------

// File: rtl/barrel_pkg.sv
// Shared constants, direction encoding and bit-reversal helper for the
// barrel shifter.
package barrel_pkg;

    localparam int WIDTH   = 32;
    localparam int SHIFT_W = $clog2(WIDTH);

    typedef enum logic {
        DIR_RIGHT = 1'b0,
        DIR_LEFT  = 1'b1
    } dir_e;

    // Mirror a WIDTH-bit word so bit i moves to bit WIDTH-1-i.
    function automatic logic [WIDTH-1:0] bit_reverse(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = v[WIDTH-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/barrel_stage.sv
// One log-shifter level: logical right shift by a fixed distance when enabled.
module barrel_stage #(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_d
);

    // Zero-fill from the top; no sign extension.
    assign o_d = i_en ? (i_d >> DIST) : i_d;

endmodule

// File: rtl/multifunctional_barrel_shifter.sv
// Registered 32-bit logical barrel shifter. Left shifts reuse the right-shift
// levels by mirroring the operand on the way in and the result on the way out.
module multifunctional_barrel_shifter
    import barrel_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   A,
    input  logic [SHIFT_W-1:0] shift,
    input  logic               L,
    output logic [WIDTH-1:0]   B
);

    dir_e             w_dir;
    logic [WIDTH-1:0] w_src;
    logic [WIDTH-1:0] w_core;
    logic [WIDTH-1:0] w_res;

    assign w_dir = dir_e'(L);
    assign w_src = (w_dir == DIR_LEFT) ? bit_reverse(A) : A;

    // Level k shifts right by 2^k when shift[k] is set.
    for (genvar k = 0; k < SHIFT_W; k++) begin : g_stage
        logic [WIDTH-1:0] w_in;
        logic [WIDTH-1:0] w_out;

        if (k == 0) begin : g_first
            assign w_in = w_src;
        end else begin : g_next
            assign w_in = g_stage[k-1].w_out;
        end

        barrel_stage #(
            .WIDTH (WIDTH),
            .DIST  (1 << k)
        ) u_stage (
            .i_en (shift[k]),
            .i_d  (w_in),
            .o_d  (w_out)
        );
    end

    assign w_core = g_stage[SHIFT_W-1].w_out;
    assign w_res  = (w_dir == DIR_LEFT) ? bit_reverse(w_core) : w_core;

    // Output register; synchronous reset takes priority over the datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            B <= '0;
        end else begin
            B <= w_res;
        end
    end

endmodule

// File: tb/tb_multifunctional_barrel_shifter.sv
// Self-checking bench for the registered barrel shifter: directed vectors,
// full shift sweeps, direction toggling, mid-sweep reset and random traffic.
module tb_multifunctional_barrel_shifter;

    logic        clk;
    logic        rst;
    logic [31:0] A;
    logic [4:0]  shift;
    logic        L;
    logic [31:0] B;

    int checks;
    int failures;

    multifunctional_barrel_shifter dut (
        .clk   (clk),
        .rst   (rst),
        .A     (A),
        .shift (shift),
        .L     (L),
        .B     (B)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain logical shift in the requested direction.
    function automatic logic [31:0] ref_shift(input logic [31:0] a, input int s, input logic l);
        return l ? (a << s) : (a >> s);
    endfunction

    task automatic check(input string tag, input logic [31:0] exp);
        checks++;
        assert (B === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, B, exp);
        end
    endtask

    // Drive inputs away from the edge, clock once, compare one cycle later.
    task automatic step(input logic r, input logic [31:0] a, input logic [4:0] s,
                        input logic l, input string tag, input logic [31:0] exp);
        @(negedge clk);
        rst   = r;
        A     = a;
        shift = s;
        L     = l;
        @(posedge clk);
        #1;
        check(tag, exp);
    endtask

    initial begin
        logic [31:0] a0;
        logic [31:0] ra;
        logic [4:0]  rs;
        logic        rl;
        checks   = 0;
        failures = 0;
        a0    = 32'h2D93FB1A;
        rst   = 1'b1;
        A     = 32'hFFFF_FFFF;
        shift = 5'd3;
        L     = 1'b1;

        // Reset held for two edges with live inputs.
        step(1'b1, 32'hFFFF_FFFF, 5'd3, 1'b1, "reset0", 32'h0);
        step(1'b1, a0,            5'd0, 1'b0, "reset1", 32'h0);
        // First edge after release carries the data.
        step(1'b0, a0, 5'd0, 1'b0, "release", a0);

        // Right shifts.
        step(1'b0, a0, 5'd0,  1'b0, "r0",  32'h2D93FB1A);
        step(1'b0, a0, 5'd1,  1'b0, "r1",  32'h16C9FD8D);
        step(1'b0, a0, 5'd4,  1'b0, "r4",  32'h02D93FB1);
        step(1'b0, a0, 5'd31, 1'b0, "r31", 32'h00000000);
        // Left shifts.
        step(1'b0, a0, 5'd0,  1'b1, "l0",  32'h2D93FB1A);
        step(1'b0, a0, 5'd1,  1'b1, "l1",  32'h5B27F634);
        step(1'b0, a0, 5'd4,  1'b1, "l4",  32'hD93FB1A0);
        step(1'b0, a0, 5'd31, 1'b1, "l31", 32'h00000000);
        // End bits crossing the full width.
        step(1'b0, 32'h80000001, 5'd31, 1'b0, "edge_r31", 32'h00000001);
        step(1'b0, 32'h80000001, 5'd31, 1'b1, "edge_l31", 32'h80000000);

        // Sweeps, right then left, with a one-cycle reset pulse mid right sweep.
        for (int s = 0; s < 32; s++) begin
            if (s == 10) begin
                step(1'b1, a0, 5'(s), 1'b0, "sweep_rst", 32'h0);
            end
            step(1'b0, a0, 5'(s), 1'b0, "sweep_r", ref_shift(a0, s, 1'b0));
        end
        for (int s = 0; s < 32; s++) begin
            step(1'b0, a0, 5'(s), 1'b1, "sweep_l", ref_shift(a0, s, 1'b1));
        end

        // Direction flipping every cycle with shift held.
        for (int i = 0; i < 8; i++) begin
            step(1'b0, a0, 5'd7, 1'(i & 1), "toggle_l", ref_shift(a0, 7, 1'(i & 1)));
        end

        // Random operands, amounts and directions.
        for (int i = 0; i < 200; i++) begin
            ra = $urandom;
            rs = 5'($urandom_range(31, 0));
            rl = 1'($urandom_range(1, 0));
            step(1'b0, ra, rs, rl, "random", ref_shift(ra, int'(rs), rl));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
